// File: rtl/xval_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xval_pkg
// Description : Shared types and helpers for the dual-rail (value/known)
//               X-aware serial link: FSM states, dual-rail bit, popcount.
// Revision    : 1.0 - initial release
// ============================================================================
package xval_pkg;

  // Widest vector the shared popcount helper accepts.
  localparam int POP_MAX = 256;

  // Word-framing FSM states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // One canonical dual-rail bit; val is already forced to 0 when unknown.
  typedef struct packed {
    logic val;
    logic known;
  } xbit_t;

  // Number of ones in v; narrower callers zero-extend their operand.
  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xval_out_buf.sv
`default_nettype none
// ============================================================================
// Module      : xval_out_buf
// Description : One-entry valid/ready holding register for completed words,
//               with sticky overflow detection when a word arrives full.
// Revision    : 1.0 - initial release
// ============================================================================
module xval_out_buf
  import xval_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_known,
  input  logic [CW-1:0]    in_xcount,
  input  logic             ready,
  input  logic             ovf_clr,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] known,
  output logic [CW-1:0]    xcount,
  output logic             ovf
);

  // A word can enter when the slot is empty or is being drained this cycle.
  logic can_take;
  logic dropped;

  assign can_take = !valid || ready;
  assign dropped  = load && valid && !ready;

  // Holding register: load on completion, release on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      data   <= '0;
      known  <= '0;
      xcount <= '0;
    end else if (load && can_take) begin
      valid  <= 1'b1;
      data   <= in_data;
      known  <= in_known;
      xcount <= in_xcount;
    end else if (valid && ready) begin
      valid  <= 1'b0;
    end
  end

  // Sticky overflow; a drop in the same cycle as the clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (dropped) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/xval_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : xval_deserializer
// Description : Receiver for the serial dual-rail X-aware link. Frames WIDTH
//               strobed bits into a word, counts X bits, flags framing errors
//               and hands words to a one-entry valid/ready output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module xval_deserializer
  import xval_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CW        = $clog2(WIDTH + 1)
) (
  input  logic             CK,
  input  logic             RS,
  input  logic             s_en,
  input  logic             s_start,
  input  logic             s_d,
  input  logic             s_v,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [WIDTH-1:0] o_known,
  output logic [CW-1:0]    o_xcount,
  output logic             o_err,
  output logic             o_ovf,
  input  logic             ovf_clr
);

  localparam int              CNTW     = $clog2(WIDTH);
  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(WIDTH - 1);

  state_t            state, state_n;
  logic [CNTW-1:0]   cnt, cnt_n;
  logic [CNTW-1:0]   bit_idx;
  logic [CNTW-1:0]   bit_pos;
  logic              wr_en;
  logic              done, done_n;
  logic              err, err_n;
  logic [WIDTH-1:0]  sh_val, sh_known;
  logic [CW-1:0]     word_xcount;
  xbit_t             in_bit;

  // Canonical form of the incoming bit: X always carries value 0.
  assign in_bit = '{val: s_d & s_v, known: s_v};

  // Logical bit index to physical position in the word.
  if (LSB_FIRST) begin : g_lsb_first
    assign bit_pos = bit_idx;
  end else begin : g_msb_first
    assign bit_pos = LAST_IDX - bit_idx;
  end

  // Next-state logic: framing, bit counting, completion and error detect.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_idx = '0;
    wr_en   = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (s_en && s_start) begin
          wr_en   = 1'b1;
          cnt_n   = CNTW'(1);
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (s_en) begin
          wr_en = 1'b1;
          if (s_start) begin
            // Restart mid-word: drop the partial word, keep this bit as bit 0.
            err_n = 1'b1;
            cnt_n = CNTW'(1);
          end else begin
            bit_idx = cnt;
            if (cnt == LAST_IDX) begin
              cnt_n   = '0;
              done_n  = 1'b1;
              state_n = IDLE;
            end else begin
              cnt_n = cnt + CNTW'(1);
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Control registers: state, bit counter, completion and error pulses.
  always_ff @(posedge CK) begin
    if (RS) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

  // Shift register: each strobed bit lands directly at its word position.
  always_ff @(posedge CK) begin
    if (RS) begin
      sh_val   <= '0;
      sh_known <= '0;
    end else if (wr_en) begin
      sh_val[bit_pos]   <= in_bit.val;
      sh_known[bit_pos] <= in_bit.known;
    end
  end

  // X count of the completed word; sampled by the buffer together with it.
  assign word_xcount = CW'(WIDTH) - CW'(popcount(POP_MAX'(sh_known)));

  assign o_err = err;

  xval_out_buf #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_out_buf (
    .clk       (CK),
    .rst       (RS),
    .load      (done),
    .in_data   (sh_val),
    .in_known  (sh_known),
    .in_xcount (word_xcount),
    .ready     (o_ready),
    .ovf_clr   (ovf_clr),
    .valid     (o_valid),
    .data      (o_data),
    .known     (o_known),
    .xcount    (o_xcount),
    .ovf       (o_ovf)
  );

endmodule
`default_nettype wire

// File: tb/tb_xval_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_xval_deserializer
// Description : Self-checking bench for xval_deserializer (WIDTH=8, LSB first).
//               Stimulus pushes expected words into a queue; a monitor pops
//               and compares on every accepted output word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xval_deserializer;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          CK = 1'b0;
  logic          RS = 1'b1;
  logic          s_en = 1'b0, s_start = 1'b0, s_d = 1'b0, s_v = 1'b0;
  logic          o_ready = 1'b0, ovf_clr = 1'b0;
  logic          o_valid, o_err, o_ovf;
  logic [W-1:0]  o_data, o_known;
  logic [CW-1:0] o_xcount;

  xval_deserializer #(
    .WIDTH     (W),
    .LSB_FIRST (1'b1)
  ) dut (
    .CK       (CK),
    .RS       (RS),
    .s_en     (s_en),
    .s_start  (s_start),
    .s_d      (s_d),
    .s_v      (s_v),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_known  (o_known),
    .o_xcount (o_xcount),
    .o_err    (o_err),
    .o_ovf    (o_ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 CK = ~CK;

  typedef struct {
    logic [W-1:0]  d;
    logic [W-1:0]  k;
    logic [CW-1:0] x;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;
  int   err_seen = 0;
  int   err_exp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: count error pulses and score every accepted word.
  always @(negedge CK) begin
    if (!RS && o_err) err_seen++;
    if (!RS && o_valid && o_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word", o_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("word_data", {24'd0, o_data}, {24'd0, mon_e.d});
        chk("word_known", {24'd0, o_known}, {24'd0, mon_e.k});
        chk("word_xcount", {28'd0, o_xcount}, {28'd0, mon_e.x});
      end
    end
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic drive_bit(input logic start, input logic d, input logic v);
    s_en = 1'b1; s_start = start; s_d = d; s_v = v;
    tick();
    s_en = 1'b0; s_start = 1'b0; s_d = 1'b0; s_v = 1'b0;
  endtask

  // Reference model: a word shows X bits as 0, known mask as sent,
  // and xcount is the number of unknown bits.
  task automatic send_word(input logic [W-1:0] d, input logic [W-1:0] v,
                           input int maxgap, input bit expect_out);
    exp_t e;
    if (expect_out) begin
      e.d = d & v;
      e.k = v;
      e.x = CW'(W - $countones(v));
      exp_q.push_back(e);
    end
    for (int i = 0; i < W; i++) begin
      drive_bit(i == 0, d[i], v[i]);
      if (i < W - 1 && maxgap > 0) repeat ($urandom_range(0, maxgap)) tick();
    end
  endtask

  task automatic send_partial(input int n, input logic [W-1:0] d);
    for (int i = 0; i < n; i++) drive_bit(i == 0, d[i], 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int err_before;
    // Reset state
    repeat (2) tick();
    RS = 1'b0;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_data", {24'd0, o_data}, 32'd0);
    chk("rst_known", {24'd0, o_known}, 32'd0);
    chk("rst_xcount", {28'd0, o_xcount}, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    chk("rst_ovf", {31'd0, o_ovf}, 32'd0);

    // 0xA5 fully known, back to back; latency of one register stage
    o_ready = 1'b0;
    send_word(8'hA5, 8'hFF, 0, 1'b1);
    chk("a5_not_yet_valid", {31'd0, o_valid}, 32'd0);
    tick();
    chk("a5_valid", {31'd0, o_valid}, 32'd1);
    chk("a5_data", {24'd0, o_data}, 32'hA5);
    chk("a5_known", {24'd0, o_known}, 32'hFF);
    chk("a5_xcount", {28'd0, o_xcount}, 32'd0);
    chk("a5_err", {31'd0, o_err}, 32'd0);
    tick();
    chk("a5_held_data", {24'd0, o_data}, 32'hA5);
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    chk("a5_valid_dropped", {31'd0, o_valid}, 32'd0);

    // X bits 3 and 6
    o_ready = 1'b1;
    send_word(8'hFF, 8'hB7, 0, 1'b1);
    tick();
    chk("x2_valid", {31'd0, o_valid}, 32'd1);
    chk("x2_xcount", {28'd0, o_xcount}, 32'd2);
    tick();

    // Overflow: 0x22 dropped while 0x11 waits
    o_ready = 1'b0;
    send_word(8'h11, 8'hFF, 0, 1'b1);
    send_word(8'h22, 8'hFF, 0, 1'b0);
    repeat (2) tick();
    chk("ovf_valid", {31'd0, o_valid}, 32'd1);
    chk("ovf_data_held", {24'd0, o_data}, 32'h11);
    chk("ovf_set", {31'd0, o_ovf}, 32'd1);
    ovf_clr = 1'b1; o_ready = 1'b1;
    tick();
    ovf_clr = 1'b0; o_ready = 1'b0;
    chk("ovf_clr_valid", {31'd0, o_valid}, 32'd0);
    chk("ovf_cleared", {31'd0, o_ovf}, 32'd0);

    // Consume and reload in the same cycle
    send_word(8'h33, 8'hFF, 0, 1'b1);
    repeat (3) tick();
    send_word(8'h44, 8'hFF, 0, 1'b1);
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    chk("swap_valid", {31'd0, o_valid}, 32'd1);
    chk("swap_data", {24'd0, o_data}, 32'h44);
    chk("swap_no_ovf", {31'd0, o_ovf}, 32'd0);
    o_ready = 1'b1;
    tick();

    // Framing error: 5 bits, then restart with 0x5A
    err_before = err_seen;
    send_partial(5, 8'hFF);
    err_exp++;
    send_word(8'h5A, 8'hFF, 0, 1'b1);
    repeat (3) tick();
    chk("frame_err_pulses", err_seen - err_before, 32'd1);

    // Reset mid-word discards the partial word
    err_before = err_seen;
    send_partial(4, 8'hF0);
    RS = 1'b1;
    tick();
    RS = 1'b0;
    chk("midword_rst_valid", {31'd0, o_valid}, 32'd0);
    send_word(8'hC3, 8'hFF, 0, 1'b1);
    repeat (3) tick();
    chk("midword_rst_no_err", err_seen - err_before, 32'd0);

    // Randomized traffic with gaps, idle noise and framing errors
    o_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] d, v, pd;
      d  = W'($urandom);
      v  = W'($urandom) | W'($urandom);
      pd = W'($urandom);
      repeat ($urandom_range(0, 2)) drive_bit(1'b0, 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) tick();
      if ($urandom_range(0, 3) == 0) begin
        send_partial($urandom_range(1, W - 1), pd);
        err_exp++;
      end
      send_word(d, v, 3, 1'b1);
    end
    repeat (5) tick();
    chk("rand_queue_drained", exp_q.size(), 32'd0);
    chk("rand_err_total", err_seen, err_exp);
    chk("rand_no_ovf", {31'd0, o_ovf}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xval_deserializer.md
Name: xval_deserializer

Overview:
- Receiving end of the serial dual-rail (value/known) link that carries X-aware words between netlist-level test harnesses.
- Accepts one bit per strobe: value rail plus known rail, where known=0 means X.
- Frames WIDTH bits into a word and presents it on a valid/ready output with one word of buffering.
- Reports the X count per word, framing errors and overflow. Counterpart of the existing serializer that drives the same link.

Parameters:
- WIDTH, 8, bits per word (>=2)
- LSB_FIRST, 1, 1 = first serial bit lands in bit 0; 0 = first bit lands in bit WIDTH-1
- CW, $clog2(WIDTH+1), width of X-count field (derived, do not override)

Ports:
- CK  input  1  clock, all logic on rising edge
- RS  input  1  reset, synchronous, active-high
- s_en  input  1  bit strobe; s_d/s_v/s_start sampled only when high
- s_start  input  1  marks current bit as bit 0 of a new word
- s_d  input  1  value rail
- s_v  input  1  known rail (0 = X)
- o_valid  output  1  output word available
- o_ready  input  1  consumer accepts word when o_valid&o_ready
- o_data  output  WIDTH  word values, X bits forced to 0
- o_known  output  WIDTH  per-bit known mask
- o_xcount  output  CW  number of zeros in o_known
- o_err  output  1  one-cycle pulse on framing error
- o_ovf  output  1  sticky overflow flag
- ovf_clr  input  1  clears o_ovf

Behaviour:
- Reset: RS high at an edge returns all state to reset values.
  - Outputs: o_valid=0, o_data=0, o_known=0, o_xcount=0, o_err=0, o_ovf=0.
  - FSM goes to IDLE; bit counter=0; partial word is discarded.
  - RS overrides all other inputs in that cycle, including mid-word.
- FSM states:
  - IDLE: s_en&s_start stores bit 0 and goes to SHIFT. s_en without s_start is ignored.
  - SHIFT: each s_en stores the next bit and increments the counter. When the WIDTH-th bit is stored, the word is complete and the FSM returns to IDLE.
  - WIDTH=... no special case: a word needs exactly WIDTH strobes.
- Framing error: s_en&s_start in SHIFT with counter>0.
  - o_err pulses high for the cycle after.
  - Partial word is dropped.
  - The current bit is stored as bit 0 of a new word; FSM stays in SHIFT.
- Gaps: s_en may be low for any number of cycles between bits; the counter holds.
- Canonicalisation: each stored bit is value = s_d & s_v, known = s_v.
- X count: computed on completion. o_xcount = WIDTH minus popcount(known) and is registered with the word.
- Latency: last bit strobed at edge t gives o_valid=1 after edge t+1 (one register stage). The next word's bit 0 may arrive at t+1.
- Output buffer is one entry, separate from the shift register. On completion:
  - Buffer empty: load the word, o_valid=1.
  - Buffer full and o_ready=1 in the same cycle: the old word is consumed and the new word loaded; o_valid stays 1; no overflow.
  - Buffer full and o_ready=0: the new word is dropped, o_ovf set, buffer unchanged.
- Handshake rules:
  - o_data/o_known/o_xcount stay stable while o_valid&!o_ready.
  - o_valid drops after acceptance unless a new word completes in the same cycle.
- o_ovf: sticky. ovf_clr clears it; if an overflow occurs in the same cycle as ovf_clr, set wins.
- o_err and an overflow may occur in the same cycle; they are independent.

Decomposition:
- Package xval_pkg holds:
  - FSM state enum {IDLE, SHIFT}
  - a dual-rail bit struct {val, known}
  - a popcount function shared with the serializer
- One natural sub-module: xval_out_buf, the one-entry valid/ready holding register with overflow detect. The shift/framing FSM stays in the top level.

Test Plan (WIDTH=8, LSB_FIRST=1):
- Send 0xA5, all known, back-to-back strobes -> one cycle after the 8th bit: o_valid=1, o_data=0xA5, o_known=0xFF, o_xcount=0, o_err=0.
- Send s_d=0xFF with s_v=0 on bits 3 and 6 -> o_data=0xB7, o_known=0xB7, o_xcount=2.
- Hold o_ready=0, send 0x11 then 0x22 -> o_data stays 0x11, o_ovf=1. Then ovf_clr=1, o_ready=1 -> 0x11 accepted, o_valid=0, o_ovf=0.
- Hold o_ready=0, send 0x33; pulse o_ready=1 exactly on the completion cycle of 0x44 -> 0x33 accepted, 0x44 presented, o_ovf=0.
- Send 5 bits of 0xFF, then s_start with the next bit, then 7 more bits of 0x5A -> o_err pulses once, output is 0x5A, the partial word is never presented.
- Send 4 bits, assert RS for 1 cycle, then send full 0xC3 -> o_err=0, o_data=0xC3; no word from the pre-reset bits.
